// File: rtl/ex_operand_stage_pkg.sv
// Shared MIPS pipeline constants: datapath widths and the ALU opcode encoding.
package mips_pkg;
   localparam int DW  = 32;
   localparam int RW  = 5;
   localparam int OPW = 5;

   localparam logic [RW-1:0] REG_ZERO = 5'd0;

   localparam logic [OPW-1:0] A_NOP      = 5'h0;
   localparam logic [OPW-1:0] A_ADD      = 5'h1;
   localparam logic [OPW-1:0] A_SUB      = 5'h2;
   localparam logic [OPW-1:0] A_AND      = 5'h3;
   localparam logic [OPW-1:0] A_OR       = 5'h4;
   localparam logic [OPW-1:0] A_XOR      = 5'h5;
   localparam logic [OPW-1:0] A_NOR      = 5'h6;
   localparam logic [OPW-1:0] A_ZERO     = 5'h7;
   localparam logic [OPW-1:0] A_LShift16 = 5'h8;
   localparam logic [OPW-1:0] A_SLL      = 5'h9;
   localparam logic [OPW-1:0] A_SRL      = 5'h10;

   // True when a writeback source should override the register-file value of src.
   function automatic logic fwd_hit(input logic we, input logic [RW-1:0] rd,
                                    input logic [RW-1:0] src);
      return we && (rd != REG_ZERO) && (rd == src);
   endfunction
endpackage

// File: rtl/ex_operand_stage_if.sv
// ID->EX bundle: decoded instruction, forward sources, and the EX/ALU-side results.
interface ex_operand_stage_if #(
   parameter int DW  = mips_pkg::DW,
   parameter int RW  = mips_pkg::RW,
   parameter int OPW = mips_pkg::OPW
);
   logic           id_valid;
   logic [OPW-1:0] id_alu_op;
   logic [RW-1:0]  id_rs, id_rt, id_rd;
   logic           id_rs_used, id_rt_used;
   logic [DW-1:0]  id_rs_val, id_rt_val, id_imm;
   logic [RW-1:0]  id_shamt;
   logic           id_use_imm, id_use_shamt;
   logic           id_reg_write, id_mem_read, id_mem_write;
   logic           flush, stall_in;
   logic           exmem_reg_write;
   logic [RW-1:0]  exmem_rd;
   logic [DW-1:0]  exmem_result;
   logic           memwb_reg_write;
   logic [RW-1:0]  memwb_rd;
   logic [DW-1:0]  memwb_result;

   logic           hazard_stall;
   logic           ex_valid;
   logic [DW-1:0]  alu_a, alu_b;
   logic [OPW-1:0] alu_op;
   logic [RW-1:0]  ex_rd;
   logic           ex_reg_write, ex_mem_read, ex_mem_write;
   logic [DW-1:0]  ex_store_data;

   modport master (
      output id_valid, id_alu_op, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
             id_rs_val, id_rt_val, id_imm, id_shamt, id_use_imm, id_use_shamt,
             id_reg_write, id_mem_read, id_mem_write, flush, stall_in,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      input  hazard_stall, ex_valid, alu_a, alu_b, alu_op, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
   );

   modport slave (
      input  id_valid, id_alu_op, id_rs, id_rt, id_rd, id_rs_used, id_rt_used,
             id_rs_val, id_rt_val, id_imm, id_shamt, id_use_imm, id_use_shamt,
             id_reg_write, id_mem_read, id_mem_write, flush, stall_in,
             exmem_reg_write, exmem_rd, exmem_result,
             memwb_reg_write, memwb_rd, memwb_result,
      output hazard_stall, ex_valid, alu_a, alu_b, alu_op, ex_rd,
             ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data
   );
endinterface

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-source operand forwarding: EX/MEM beats MEM/WB beats the captured register value.
module fwd_mux
   import mips_pkg::*;
#(
   parameter int DW = mips_pkg::DW
) (
   input  logic [RW-1:0] src,
   input  logic          used,
   input  logic [DW-1:0] reg_val,
   input  logic          exmem_reg_write,
   input  logic [RW-1:0] exmem_rd,
   input  logic [DW-1:0] exmem_result,
   input  logic          memwb_reg_write,
   input  logic [RW-1:0] memwb_rd,
   input  logic [DW-1:0] memwb_result,
   output logic [DW-1:0] operand
);
   always_comb begin
      operand = reg_val;
      if (src == REG_ZERO)
         operand = '0;
      else if (used && fwd_hit(exmem_reg_write, exmem_rd, src))
         operand = exmem_result;
      else if (used && fwd_hit(memwb_reg_write, memwb_rd, src))
         operand = memwb_result;
   end
endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX register with forwarding, operand select and load-use hazard detection.
// Optional EX_BUBBLE_CNT_EN adds a saturating count of hazard-inserted bubbles.
module ex_operand_stage
   import mips_pkg::*;
#(
   parameter int DW  = mips_pkg::DW,
   parameter int RW  = mips_pkg::RW,
   parameter int OPW = mips_pkg::OPW
) (
   input  logic clk,
   input  logic rst_n,
   ex_operand_stage_if.slave bus
`ifdef EX_BUBBLE_CNT_EN
   ,
   output logic [31:0] bubble_count
`endif
);
   logic           ex_valid_reg;
   logic [OPW-1:0] alu_op_reg;
   logic [RW-1:0]  rd_reg, rs_reg, rt_reg, shamt_reg;
   logic           reg_write_reg, mem_read_reg, mem_write_reg;
   logic           rs_used_reg, rt_used_reg, use_imm_reg, use_shamt_reg;
   logic [DW-1:0]  rs_val_reg, rt_val_reg, imm_reg;
   logic           hazard;

   logic [RW-1:0]  src_idx  [2];
   logic           src_used [2];
   logic [DW-1:0]  src_val  [2];
   logic [DW-1:0]  fwd_val  [2];

   // Only a valid load in EX writing a nonzero register can create a load-use stall.
   assign hazard = bus.id_valid & ex_valid_reg & mem_read_reg & (rd_reg != '0)
                 & ((bus.id_rs_used & (bus.id_rs == rd_reg))
                  | (bus.id_rt_used & (bus.id_rt == rd_reg)))
                 & ~bus.flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_reg  <= 1'b0;
         alu_op_reg    <= A_NOP;
         rd_reg        <= '0;
         rs_reg        <= '0;
         rt_reg        <= '0;
         shamt_reg     <= '0;
         reg_write_reg <= 1'b0;
         mem_read_reg  <= 1'b0;
         mem_write_reg <= 1'b0;
         rs_used_reg   <= 1'b0;
         rt_used_reg   <= 1'b0;
         use_imm_reg   <= 1'b0;
         use_shamt_reg <= 1'b0;
         rs_val_reg    <= '0;
         rt_val_reg    <= '0;
         imm_reg       <= '0;
      end else if (!bus.stall_in) begin
         if (bus.flush || hazard) begin
            ex_valid_reg  <= 1'b0;
            alu_op_reg    <= A_NOP;
            rd_reg        <= '0;
            rs_reg        <= '0;
            rt_reg        <= '0;
            shamt_reg     <= '0;
            reg_write_reg <= 1'b0;
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            rs_used_reg   <= 1'b0;
            rt_used_reg   <= 1'b0;
            use_imm_reg   <= 1'b0;
            use_shamt_reg <= 1'b0;
            rs_val_reg    <= '0;
            rt_val_reg    <= '0;
            imm_reg       <= '0;
         end else begin
            ex_valid_reg  <= bus.id_valid;
            alu_op_reg    <= bus.id_valid ? bus.id_alu_op : A_NOP;
            rd_reg        <= bus.id_valid ? bus.id_rd : '0;
            reg_write_reg <= bus.id_valid & bus.id_reg_write;
            mem_read_reg  <= bus.id_valid & bus.id_mem_read;
            mem_write_reg <= bus.id_valid & bus.id_mem_write;
            rs_reg        <= bus.id_rs;
            rt_reg        <= bus.id_rt;
            shamt_reg     <= bus.id_shamt;
            rs_used_reg   <= bus.id_rs_used;
            rt_used_reg   <= bus.id_rt_used;
            use_imm_reg   <= bus.id_use_imm;
            use_shamt_reg <= bus.id_use_shamt;
            rs_val_reg    <= bus.id_rs_val;
            rt_val_reg    <= bus.id_rt_val;
            imm_reg       <= bus.id_imm;
         end
      end
   end

   assign src_idx[0]  = rs_reg;
   assign src_idx[1]  = rt_reg;
   assign src_used[0] = rs_used_reg;
   assign src_used[1] = rt_used_reg;
   assign src_val[0]  = rs_val_reg;
   assign src_val[1]  = rt_val_reg;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
         fwd_mux #(.DW(DW)) u_fwd (
            .src             (src_idx[gi]),
            .used            (src_used[gi]),
            .reg_val         (src_val[gi]),
            .exmem_reg_write (bus.exmem_reg_write),
            .exmem_rd        (bus.exmem_rd),
            .exmem_result    (bus.exmem_result),
            .memwb_reg_write (bus.memwb_reg_write),
            .memwb_rd        (bus.memwb_rd),
            .memwb_result    (bus.memwb_result),
            .operand         (fwd_val[gi])
         );
      end
   endgenerate

   assign bus.hazard_stall  = hazard;
   assign bus.ex_valid      = ex_valid_reg;
   assign bus.alu_op        = alu_op_reg;
   assign bus.ex_rd         = rd_reg;
   assign bus.ex_reg_write  = reg_write_reg;
   assign bus.ex_mem_read   = mem_read_reg;
   assign bus.ex_mem_write  = mem_write_reg;
   assign bus.alu_a         = use_shamt_reg ? {{(DW-RW){1'b0}}, shamt_reg} : fwd_val[0];
   assign bus.alu_b         = use_imm_reg ? imm_reg : fwd_val[1];
   assign bus.ex_store_data = fwd_val[1];

`ifdef EX_BUBBLE_CNT_EN
   logic [31:0] bubble_count_reg;

   // hazard already excludes flush, so flush bubbles are never counted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         bubble_count_reg <= '0;
      else if (!bus.stall_in && hazard && (bubble_count_reg != 32'hFFFF_FFFF))
         bubble_count_reg <= bubble_count_reg + 32'd1;
   end

   assign bubble_count = bubble_count_reg;
`endif
endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed self-checking bench for ex_operand_stage.
module tb_ex_operand_stage;
   import mips_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   int   checks = 0;
   int   failures = 0;

   ex_operand_stage_if bus ();
`ifdef EX_BUBBLE_CNT_EN
   logic [31:0] bubble_count;
`endif

   ex_operand_stage dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
`ifdef EX_BUBBLE_CNT_EN
      ,
      .bubble_count (bubble_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic clear_fwd;
      bus.exmem_reg_write = 1'b0; bus.exmem_rd = '0; bus.exmem_result = '0;
      bus.memwb_reg_write = 1'b0; bus.memwb_rd = '0; bus.memwb_result = '0;
   endtask

   task automatic drive_id(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic rsu, input logic rtu,
                           input logic [31:0] rsv, input logic [31:0] rtv,
                           input logic [31:0] imm, input logic [4:0] sh,
                           input logic ui, input logic us, input logic rw,
                           input logic mr, input logic mw);
      bus.id_valid = 1'b1; bus.id_alu_op = op;
      bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
      bus.id_rs_used = rsu; bus.id_rt_used = rtu;
      bus.id_rs_val = rsv; bus.id_rt_val = rtv; bus.id_imm = imm; bus.id_shamt = sh;
      bus.id_use_imm = ui; bus.id_use_shamt = us;
      bus.id_reg_write = rw; bus.id_mem_read = mr; bus.id_mem_write = mw;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (bus.ex_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", bus.ex_valid); end
      checks++; if (bus.alu_op !== 5'd0) begin failures++; $display("FAIL reset_op got=%0h exp=0", bus.alu_op); end
      checks++; if (bus.alu_a !== 32'd0 || bus.alu_b !== 32'd0) begin failures++; $display("FAIL reset_alu got=%0h/%0h exp=0/0", bus.alu_a, bus.alu_b); end
      checks++; if (bus.ex_rd !== 5'd0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0) begin failures++; $display("FAIL reset_ctrl rd=%0h rw=%0h mr=%0h exp=0", bus.ex_rd, bus.ex_reg_write, bus.ex_mem_read); end
      checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%0h exp=0", bus.hazard_stall); end
      $display("reset: valid=%0h op=%0h", bus.ex_valid, bus.alu_op);
      tick;
      rst_n = 1'b1;
   endtask

   task automatic test_add;
      drive_id(A_ADD, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick;
      checks++; if (bus.ex_valid !== 1'b1 || bus.alu_op !== 5'd1) begin failures++; $display("FAIL add_op valid=%0h op=%0h exp=1/1", bus.ex_valid, bus.alu_op); end
      checks++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin failures++; $display("FAIL add_operands got=%0d/%0d exp=5/7", bus.alu_a, bus.alu_b); end
      checks++; if (bus.ex_rd !== 5'd9 || bus.ex_reg_write !== 1'b1 || bus.ex_store_data !== 32'd7) begin failures++; $display("FAIL add_ctrl rd=%0d rw=%0h sd=%0d exp=9/1/7", bus.ex_rd, bus.ex_reg_write, bus.ex_store_data); end
      $display("add: a=%0d b=%0d op=%0d", bus.alu_a, bus.alu_b, bus.alu_op);
   endtask

   task automatic test_forward;
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd3; bus.exmem_result = 32'd100;
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd3; bus.memwb_result = 32'd200;
      #1;
      checks++; if (bus.alu_a !== 32'd100) begin failures++; $display("FAIL fwd_exmem_priority got=%0d exp=100", bus.alu_a); end
      bus.exmem_reg_write = 1'b0;
      #1;
      checks++; if (bus.alu_a !== 32'd200) begin failures++; $display("FAIL fwd_memwb got=%0d exp=200", bus.alu_a); end
      bus.exmem_reg_write = 1'b1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'd99;
      bus.memwb_rd = 5'd0; bus.memwb_result = 32'd99;
      #1;
      checks++; if (bus.alu_a !== 32'd5) begin failures++; $display("FAIL fwd_rd0 got=%0d exp=5", bus.alu_a); end
      bus.memwb_rd = 5'd4; bus.memwb_result = 32'd300;
      #1;
      checks++; if (bus.alu_b !== 32'd300 || bus.ex_store_data !== 32'd300) begin failures++; $display("FAIL fwd_rt got=%0d/%0d exp=300/300", bus.alu_b, bus.ex_store_data); end
      $display("forward: a=%0d b=%0d", bus.alu_a, bus.alu_b);
      clear_fwd;
   endtask

   task automatic test_mid_reset;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (bus.ex_valid !== 1'b0 || bus.alu_op !== 5'd0) begin failures++; $display("FAIL midreset got=%0h/%0h exp=0/0", bus.ex_valid, bus.alu_op); end
      rst_n = 1'b1;
      drive_id(A_SUB, 5'd5, 5'd6, 5'd11, 1'b1, 1'b1, 32'd20, 32'd3, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick;
      checks++; if (bus.ex_valid !== 1'b1 || bus.alu_op !== 5'd2 || bus.alu_a !== 32'd20 || bus.alu_b !== 32'd3) begin failures++; $display("FAIL post_reset_load v=%0h op=%0h a=%0d b=%0d exp=1/2/20/3", bus.ex_valid, bus.alu_op, bus.alu_a, bus.alu_b); end
      $display("mid_reset: op=%0d a=%0d b=%0d", bus.alu_op, bus.alu_a, bus.alu_b);
   endtask

   task automatic test_load_use;
      drive_id(A_ADD, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 32'h10, 32'd0, 32'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick;
      checks++; if (bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd8 || bus.alu_a !== 32'h10 || bus.alu_b !== 32'd4) begin failures++; $display("FAIL lw_load mr=%0h rd=%0d a=%0h b=%0h exp=1/8/10/4", bus.ex_mem_read, bus.ex_rd, bus.alu_a, bus.alu_b); end
      drive_id(A_ADD, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 32'd0, 32'd6, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL hazard_detect got=%0h exp=1", bus.hazard_stall); end
      tick;
      checks++; if (bus.ex_valid !== 1'b0 || bus.alu_op !== 5'd0 || bus.ex_rd !== 5'd0 || bus.ex_reg_write !== 1'b0) begin failures++; $display("FAIL hazard_bubble v=%0h op=%0h rd=%0d rw=%0h exp=0/0/0/0", bus.ex_valid, bus.alu_op, bus.ex_rd, bus.ex_reg_write); end
      checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL hazard_clear got=%0h exp=0", bus.hazard_stall); end
      bus.memwb_reg_write = 1'b1; bus.memwb_rd = 5'd8; bus.memwb_result = 32'h55;
      tick;
      checks++; if (bus.ex_valid !== 1'b1 || bus.alu_op !== 5'd1 || bus.alu_a !== 32'h55 || bus.alu_b !== 32'd6) begin failures++; $display("FAIL load_use_fwd v=%0h op=%0h a=%0h b=%0d exp=1/1/55/6", bus.ex_valid, bus.alu_op, bus.alu_a, bus.alu_b); end
      $display("load_use: a=%0h b=%0d", bus.alu_a, bus.alu_b);
      clear_fwd;
   endtask

   task automatic test_flush;
      drive_id(A_ADD, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 32'h10, 32'd0, 32'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick;
      drive_id(A_ADD, 5'd8, 5'd2, 5'd10, 1'b1, 1'b1, 32'd0, 32'd6, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.flush = 1'b1;
      #1;
      checks++; if (bus.hazard_stall !== 1'b0) begin failures++; $display("FAIL flush_hazard got=%0h exp=0", bus.hazard_stall); end
      tick;
      checks++; if (bus.ex_valid !== 1'b0 || bus.alu_op !== 5'd0 || bus.ex_mem_read !== 1'b0) begin failures++; $display("FAIL flush_bubble v=%0h op=%0h mr=%0h exp=0/0/0", bus.ex_valid, bus.alu_op, bus.ex_mem_read); end
      bus.flush = 1'b0;
      $display("flush: valid=%0h", bus.ex_valid);
   endtask

   task automatic test_stall;
      drive_id(A_ADD, 5'd3, 5'd4, 5'd12, 1'b1, 1'b1, 32'd11, 32'd22, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      tick;
      bus.stall_in = 1'b1;
      drive_id(A_XOR, 5'd5, 5'd6, 5'd13, 1'b1, 1'b1, 32'd1, 32'd2, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++; if (bus.ex_valid !== 1'b1 || bus.alu_op !== 5'd1 || bus.alu_a !== 32'd11 || bus.alu_b !== 32'd22 || bus.ex_rd !== 5'd12) begin failures++; $display("FAIL stall_hold%0d op=%0h a=%0d b=%0d rd=%0d exp=1/11/22/12", i, bus.alu_op, bus.alu_a, bus.alu_b, bus.ex_rd); end
         $display("stall cycle %0d: op=%0d a=%0d", i, bus.alu_op, bus.alu_a);
      end
      bus.stall_in = 1'b0;
      drive_id(A_ADD, 5'd1, 5'd0, 5'd8, 1'b1, 1'b0, 32'h10, 32'd0, 32'd4, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      tick;
      drive_id(A_ADD, 5'd2, 5'd8, 5'd10, 1'b1, 1'b1, 32'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      bus.stall_in = 1'b1;
      #1;
      checks++; if (bus.hazard_stall !== 1'b1) begin failures++; $display("FAIL stall_hazard_flag got=%0h exp=1", bus.hazard_stall); end
      tick;
      checks++; if (bus.ex_valid !== 1'b1 || bus.ex_mem_read !== 1'b1 || bus.ex_rd !== 5'd8) begin failures++; $display("FAIL stall_hazard_hold v=%0h mr=%0h rd=%0d exp=1/1/8", bus.ex_valid, bus.ex_mem_read, bus.ex_rd); end
      bus.stall_in = 1'b0;
      $display("stall+hazard: rd=%0d mr=%0h", bus.ex_rd, bus.ex_mem_read);
   endtask

   task automatic test_shift;
      drive_id(A_SLL, 5'd0, 5'd5, 5'd3, 1'b0, 1'b1, 32'd0, 32'd1, 32'd0, 5'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      tick;
      checks++; if (bus.alu_op !== 5'd9 || bus.alu_a !== 32'd4 || bus.alu_b !== 32'd1) begin failures++; $display("FAIL sll op=%0h a=%0d b=%0d exp=9/4/1", bus.alu_op, bus.alu_a, bus.alu_b); end
      drive_id(A_LShift16, 5'd0, 5'd7, 5'd7, 1'b0, 1'b0, 32'd0, 32'hDEAD, 32'h1234, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      tick;
      checks++; if (bus.alu_op !== 5'd8 || bus.alu_b !== 32'h1234) begin failures++; $display("FAIL lui op=%0h b=%0h exp=8/1234", bus.alu_op, bus.alu_b); end
      $display("shift: lui b=%0h", bus.alu_b);
   endtask

   task automatic test_invalid;
      drive_id(A_ADD, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 32'd5, 32'd7, 32'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      bus.id_valid = 1'b0;
      tick;
      checks++; if (bus.ex_valid !== 1'b0 || bus.alu_op !== 5'd0 || bus.ex_reg_write !== 1'b0 || bus.ex_mem_write !== 1'b0 || bus.ex_rd !== 5'd0) begin failures++; $display("FAIL invalid_bubble v=%0h op=%0h rw=%0h mw=%0h rd=%0d exp=0", bus.ex_valid, bus.alu_op, bus.ex_reg_write, bus.ex_mem_write, bus.ex_rd); end
      $display("invalid: valid=%0h op=%0h", bus.ex_valid, bus.alu_op);
`ifdef EX_BUBBLE_CNT_EN
      checks++; if (bubble_count !== 32'd1) begin failures++; $display("FAIL bubble_count got=%0d exp=1", bubble_count); end
`endif
   endtask

   initial begin
      bus.id_valid = 1'b0; bus.id_alu_op = '0; bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
      bus.id_rs_used = 1'b0; bus.id_rt_used = 1'b0; bus.id_rs_val = '0; bus.id_rt_val = '0;
      bus.id_imm = '0; bus.id_shamt = '0; bus.id_use_imm = 1'b0; bus.id_use_shamt = 1'b0;
      bus.id_reg_write = 1'b0; bus.id_mem_read = 1'b0; bus.id_mem_write = 1'b0;
      bus.flush = 1'b0; bus.stall_in = 1'b0;
      clear_fwd;
      test_reset;
      test_add;
      test_forward;
      test_mid_reset;
      test_load_use;
      test_flush;
      test_stall;
      test_shift;
      test_invalid;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
